uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_pkg.sv | 31 +++
 rtl/uart_rx_fifo_mem.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared constants for the UART receive FIFO: record width, depth,
//   pointer/counter widths and the bit positions of the fields inside one
//   received-character record.
//
//   Record layout (11 bits):
//     [10:3] received data byte
//     [2]    break indication (BI)
//     [1]    parity error (PE)
//     [0]    framing error (FE)
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  localparam int UART_FIFO_REC_WIDTH = 11;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_POINTER_W = 4;
  localparam int UART_FIFO_COUNTER_W = 5;

  localparam int UART_REC_DATA_MSB = 10;
  localparam int UART_REC_DATA_LSB = 3;
  localparam int UART_REC_BI       = 2;
  localparam int UART_REC_PE       = 1;
  localparam int UART_REC_FE       = 0;

  // A record counts as erroneous when any of BI, PE or FE is set.
  function automatic logic rec_has_error(input logic [UART_FIFO_REC_WIDTH-1:0] rec);
    return rec[UART_REC_BI] | rec[UART_REC_PE] | rec[UART_REC_FE];
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mem
//   DEPTH x WIDTH register array with one synchronous write port and one
//   asynchronous read port. Each entry carries an extra error flag bit so the
//   control logic can tell whether the head record being popped was flagged.
//   The array itself is deliberately not reset; validity is tracked by the
//   occupancy count in the parent.
//
//   Ports:
//     clk        system clock
//     we         write enable (one entry per cycle)
//     waddr      write address
//     wdata      record to store
//     wflag      error flag stored alongside the record
//     raddr      read address
//     rdata      record at raddr (combinational)
//     rflag      error flag at raddr (combinational)
// ---------------------------------------------------------------------------
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = UART_FIFO_REC_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int PTR_W = UART_FIFO_POINTER_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wflag,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rflag
);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_flag [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_data[waddr] <= wdata;
      mem_flag[waddr] <= wflag;
    end
  end

  assign rdata = mem_data[raddr];
  assign rflag = mem_flag[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side FIFO between the UART frame assembler and the register file.
//   Holds one 11-bit record per received character and exposes the head
//   record (show-ahead), the occupancy count, a sticky overrun flag and a flag
//   saying that at least one stored record carries an error.
//
//   Ports:
//     clk         system clock
//     wb_rst_i    asynchronous active-high reset
//     data_in     record from the frame assembler
//     push        store data_in this cycle
//     pop         discard the head record this cycle
//     fifo_reset  synchronous flush (FCR strobe), beats push/pop
//     lsr_mask    LSR-read strobe, clears overrun
//     data_out    head record, 0 while empty
//     count       current occupancy (0..DEPTH)
//     overrun     push attempted while full (sticky)
//     error_bit   some stored record has a nonzero error field
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH     = UART_FIFO_REC_WIDTH,
  parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int FIFO_POINTER_W = UART_FIFO_POINTER_W,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_reset,
  input  logic                      lsr_mask,
  output logic [FIFO_WIDTH-1:0]     data_out,
  output logic [FIFO_COUNTER_W-1:0] count,
  output logic                      overrun,
  output logic                      error_bit
);

  localparam logic [FIFO_COUNTER_W-1:0] CNT_FULL = FIFO_COUNTER_W'(FIFO_DEPTH);
  localparam logic [FIFO_COUNTER_W-1:0] CNT_ONE  = FIFO_COUNTER_W'(1);
  localparam logic [FIFO_POINTER_W-1:0] PTR_ONE  = FIFO_POINTER_W'(1);

  logic [FIFO_POINTER_W-1:0] wr_ptr;
  logic [FIFO_POINTER_W-1:0] rd_ptr;
  logic [FIFO_COUNTER_W-1:0] err_cnt;

  logic [FIFO_WIDTH-1:0] head_rec;
  logic                  head_flag;
  logic                  in_flag;
  logic                  is_empty;
  logic                  is_full;
  logic                  push_ok;
  logic                  pop_ok;

  assign in_flag  = rec_has_error(data_in);
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_FULL);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop on an empty FIFO is simply ignored.
  assign pop_ok  = pop && !is_empty && !fifo_reset;
  assign push_ok = push && (!is_full || pop_ok) && !fifo_reset;

  uart_rx_fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_POINTER_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .wflag (in_flag),
    .raddr (rd_ptr),
    .rdata (head_rec),
    .rflag (head_flag)
  );

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power
  // of two and the pointer width is exactly log2(DEPTH).
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      count <= count + CNT_ONE;
      else if (pop_ok && !push_ok) count <= count - CNT_ONE;
    end
  end

  // Number of stored records carrying an error; moves in step with count so
  // error_bit always describes exactly the records currently held.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_cnt <= '0;
    end else if (fifo_reset) begin
      err_cnt <= '0;
    end else begin
      if ((push_ok && in_flag) && !(pop_ok && head_flag))      err_cnt <= err_cnt + CNT_ONE;
      else if ((pop_ok && head_flag) && !(push_ok && in_flag)) err_cnt <= err_cnt - CNT_ONE;
    end
  end

  // Overrun is sticky. A new overrun in the same cycle as an LSR read wins so
  // the event is never lost; a flush always clears it because the concurrent
  // push is dropped rather than overrunning.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overrun <= 1'b0;
    end else if (fifo_reset) begin
      overrun <= 1'b0;
    end else if (push && !pop && is_full) begin
      overrun <= 1'b1;
    end else if (lsr_mask) begin
      overrun <= 1'b0;
    end
  end

  // The storage array is never reset, so mask the head while empty.
  assign data_out  = is_empty ? '0 : head_rec;
  assign error_bit = (err_cnt != '0);

endmodule
